// File: rtl/alu_adder_arbiter_rv32i.sv
// alu_adder_arbiter_rv32i
//   Shares one 32-bit add/sub unit between two requesters. Round-robin
//   arbitration feeds a single operand register (stage A). Each adder result
//   lands in a per-port result buffer (stage B). Both sides use valid/ready.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   req0_valid/ready/in1/in2/type   port 0 request channel (type: 0 add, 1 sub)
//   req1_valid/ready/in1/in2/type   port 1 request channel
//   rsp0_valid/ready/out            port 0 response channel (registered)
//   rsp1_valid/ready/out            port 1 response channel (registered)

module alu_adder_rv32i (
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic        op_type,
    output logic [31:0] out
);
    // Plain modulo-2^32 arithmetic; no carry or overflow flags.
    assign out = op_type ? (in1 - in2) : (in1 + in2);
endmodule

module alu_adder_arbiter_rv32i (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_in1,
    input  logic [31:0] req0_in2,
    input  logic        req0_type,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_in1,
    input  logic [31:0] req1_in2,
    input  logic        req1_type,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_out,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_out
);
    logic        a_valid;
    logic        a_tag;
    logic        a_type;
    logic [31:0] a_in1;
    logic [31:0] a_in2;
    logic        b_valid0;
    logic        b_valid1;
    logic [31:0] buf0;
    logic [31:0] buf1;
    logic        last_grant;

    logic [31:0] sum;
    logic        a_move;
    logic        a_free;
    logic        acc0;
    logic        acc1;
    logic        wr0;
    logic        wr1;
    logic        tag_b_valid;
    logic        tag_rsp_ready;

    alu_adder_rv32i u_adder (
        .in1     (a_in1),
        .in2     (a_in2),
        .op_type (a_type),
        .out     (sum)
    );

    always_comb begin
        tag_b_valid   = a_tag ? b_valid1 : b_valid0;
        tag_rsp_ready = a_tag ? rsp1_ready : rsp0_ready;
        a_move        = a_valid & (~tag_b_valid | tag_rsp_ready);
        a_free        = ~a_valid | a_move;
        // Each ready is written without its own port's valid, so there is
        // no valid->ready loop. When the port is actually valid this equals
        // "grant == X": it wins if the other port is idle, or on a tie if it
        // was not the last one granted. rst_n forces ready low in reset.
        req0_ready    = rst_n & a_free & (~req1_valid | last_grant);
        req1_ready    = rst_n & a_free & (~req0_valid | ~last_grant);
        acc0          = req0_valid & req0_ready;
        acc1          = req1_valid & req1_ready;
        wr0           = a_move & ~a_tag;
        wr1           = a_move & a_tag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid    <= 1'b0;
            a_tag      <= 1'b0;
            a_type     <= 1'b0;
            a_in1      <= '0;
            a_in2      <= '0;
            last_grant <= 1'b1;
        end else begin
            if (acc0) begin
                a_valid    <= 1'b1;
                a_tag      <= 1'b0;
                a_type     <= req0_type;
                a_in1      <= req0_in1;
                a_in2      <= req0_in2;
                last_grant <= 1'b0;
            end else if (acc1) begin
                a_valid    <= 1'b1;
                a_tag      <= 1'b1;
                a_type     <= req1_type;
                a_in1      <= req1_in1;
                a_in2      <= req1_in2;
                last_grant <= 1'b1;
            end else if (a_move) begin
                a_valid    <= 1'b0;
            end
        end
    end

    // A write takes priority over a drain so that a drain and a write in the
    // same cycle leave the buffer full with the new result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_valid0 <= 1'b0;
            buf0     <= '0;
        end else if (wr0) begin
            b_valid0 <= 1'b1;
            buf0     <= sum;
        end else if (b_valid0 & rsp0_ready) begin
            b_valid0 <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_valid1 <= 1'b0;
            buf1     <= '0;
        end else if (wr1) begin
            b_valid1 <= 1'b1;
            buf1     <= sum;
        end else if (b_valid1 & rsp1_ready) begin
            b_valid1 <= 1'b0;
        end
    end

    assign rsp0_valid = b_valid0;
    assign rsp1_valid = b_valid1;
    assign rsp0_out   = buf0;
    assign rsp1_out   = buf1;
endmodule

// File: tb/tb_alu_adder_arbiter_rv32i.sv
module tb_alu_adder_arbiter_rv32i;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_in1 = '0, req0_in2 = '0, req1_in1 = '0, req1_in2 = '0;
    logic        req0_type = 1'b0, req1_type = 1'b0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [31:0] rsp0_out, rsp1_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_adder_arbiter_rv32i dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_in1   (req0_in1),
        .req0_in2   (req0_in2),
        .req0_type  (req0_type),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_in1   (req1_in1),
        .req1_in2   (req1_in2),
        .req1_type  (req1_type),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_out   (rsp0_out),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_out   (rsp1_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic t);
        longint unsigned r;
        if (t) r = longint'(a) + 64'h1_0000_0000 - longint'(b);
        else   r = longint'(a) + longint'(b);
        return r[31:0];
    endfunction

    // Reference: per-port FIFO of expected results in issue order, plus the
    // round-robin tie rule and a wait-time watch for starvation.
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic        lg_m = 1'b1;
    logic        acc0_seen = 1'b0, acc1_seen = 1'b0;
    int          w0 = 0, w1 = 0, max_wait = 0;

    always @(negedge clk) begin
        logic hs0, hs1;
        logic [31:0] e;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            lg_m = 1'b1;
            w0 = 0;
            w1 = 0;
            acc0_seen = 1'b0;
            acc1_seen = 1'b0;
        end else begin
            hs0 = req0_valid & req0_ready;
            hs1 = req1_valid & req1_ready;
            if (rsp0_valid & rsp0_ready) begin
                chk("rsp0_expected", 32'(q0.size() != 0), 1);
                if (q0.size() != 0) begin
                    e = q0.pop_front();
                    chk("rsp0_data", rsp0_out, e);
                end
            end
            if (rsp1_valid & rsp1_ready) begin
                chk("rsp1_expected", 32'(q1.size() != 0), 1);
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    chk("rsp1_data", rsp1_out, e);
                end
            end
            if (hs0 | hs1) begin
                chk("one_grant", 32'(hs0 & hs1), 0);
                if (req0_valid & req1_valid)
                    chk("rr_tie", 32'(hs1), 32'(!lg_m));
                lg_m = hs1;
            end
            if (hs0) begin
                q0.push_back(ref_op(req0_in1, req0_in2, req0_type));
                chk("inflight0", 32'(q0.size() <= 2), 1);
            end
            if (hs1) begin
                q1.push_back(ref_op(req1_in1, req1_in2, req1_type));
                chk("inflight1", 32'(q1.size() <= 2), 1);
            end
            w0 = (req0_valid & !hs0) ? w0 + 1 : 0;
            w1 = (req1_valid & !hs1) ? w1 + 1 : 0;
            if (w0 > max_wait) max_wait = w0;
            if (w1 > max_wait) max_wait = w1;
            acc0_seen = hs0;
            acc1_seen = hs1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        repeat (5) step();
        chk("q0_empty", 32'(q0.size()), 0);
        chk("q1_empty", 32'(q1.size()), 0);
    endtask

    initial begin
        int acc_cnt;
        int guard;
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst_rsp0_valid", 32'(rsp0_valid), 0);
        chk("rst_rsp1_valid", 32'(rsp1_valid), 0);
        chk("rst_rsp0_out", rsp0_out, 0);
        chk("rst_rsp1_out", rsp1_out, 0);

        // Single op: 5 + 7 on port 0
        step();
        req0_valid = 1'b1; req0_in1 = 5; req0_in2 = 7; req0_type = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        @(negedge clk);
        chk("single_ready", 32'(req0_ready), 1);
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("single_lat1", 32'(rsp0_valid), 0);
        step();
        @(negedge clk);
        chk("single_valid", 32'(rsp0_valid), 1);
        chk("single_out", rsp0_out, 12);
        chk("single_rsp1", 32'(rsp1_valid), 0);
        drain();

        // Contention: alternating grants, one result per cycle
        do_reset();
        req0_valid = 1'b1; req0_in1 = 10; req0_in2 = 3; req0_type = 1'b1;
        req1_valid = 1'b1; req1_in1 = 32'hFFFF_FFFF; req1_in2 = 1; req1_type = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("alt_ready0", 32'(req0_ready), 32'(i % 2 == 0));
            chk("alt_ready1", 32'(req1_ready), 32'(i % 2 == 1));
            if (i >= 2) chk("tput", 32'(rsp0_valid | rsp1_valid), 1);
            if (rsp0_valid) chk("cont_out0", rsp0_out, 7);
            if (rsp1_valid) chk("cont_out1", rsp1_out, 0);
            step();
        end
        drain();

        // Backpressure on port 0, port 1 blocked behind tag 0
        do_reset();
        rsp0_ready = 1'b0; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_in1 = 100; req0_in2 = 1; req0_type = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (req0_ready) acc_cnt++;
            step();
            if (acc0_seen) req0_in1 = req0_in1 + 100;
        end
        chk("bp_accepts", 32'(acc_cnt), 2);
        chk("bp_ready0_low", 32'(req0_ready), 0);
        req1_valid = 1'b1; req1_in1 = 9; req1_in2 = 4; req1_type = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ready1_blocked", 32'(req1_ready), 0);
            step();
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        chk("bp_resume1", 32'(req1_ready), 1);
        step();
        req1_valid = 1'b0;
        guard = 0;
        while (req0_valid && guard < 20) begin
            @(negedge clk);
            step();
            if (acc0_seen) req0_valid = 1'b0;
            guard++;
        end
        chk("bp_third_accepted", 32'(req0_valid), 0);
        drain();

        // Simultaneous drain and write: port 0 back-to-back, no bubble
        do_reset();
        rsp0_ready = 1'b1;
        req0_valid = 1'b1; req0_type = 1'b0; req0_in1 = 1; req0_in2 = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i >= 2) chk("b2b_valid0", 32'(rsp0_valid), 1);
            step();
            if (acc0_seen) req0_in1 = req0_in1 + 1;
        end
        drain();

        // Reset mid-operation
        do_reset();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        req0_valid = 1'b1; req0_in1 = 100; req0_in2 = 1; req0_type = 1'b0;
        req1_valid = 1'b1; req1_in1 = 200; req1_in2 = 2; req1_type = 1'b1;
        @(negedge clk); step();
        req0_in1 = 300;
        @(negedge clk); step();
        req1_valid = 1'b0;
        @(negedge clk); step();
        @(negedge clk);
        chk("mid_full", {30'd0, rsp0_valid, rsp1_valid}, 3);
        req1_valid = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rsp0_valid", 32'(rsp0_valid), 0);
        chk("mid_rsp1_valid", 32'(rsp1_valid), 0);
        chk("mid_rsp0_out", rsp0_out, 0);
        chk("mid_rsp1_out", rsp1_out, 0);
        chk("mid_ready", {30'd0, req0_ready, req1_ready}, 0);
        step(); step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_tie0", 32'(req0_ready), 1);
        chk("post_rst_tie1", 32'(req1_ready), 0);
        drain();

        // Random soak
        do_reset();
        max_wait = 0;
        for (int c = 0; c < 10000; c++) begin
            step();
            if (!req0_valid || acc0_seen) begin
                req0_valid = ($urandom_range(0, 9) < 6);
                req0_in1 = $urandom; req0_in2 = $urandom; req0_type = 1'($urandom);
            end
            if (!req1_valid || acc1_seen) begin
                req1_valid = ($urandom_range(0, 9) < 6);
                req1_in1 = $urandom; req1_in2 = $urandom; req1_type = 1'($urandom);
            end
            rsp0_ready = ($urandom_range(0, 9) < 7);
            rsp1_ready = ($urandom_range(0, 9) < 7);
        end
        drain();
        chk("no_starvation", 32'(max_wait < 100), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_adder_arbiter_rv32i.md
# alu_adder_arbiter_rv32i

Two-port round-robin arbiter and pipeline sequencer that shares one `alu_adder_rv32i` add/sub subblock between two requesters, e.g. the branch-target/PC path and the main ALU path. Each port has a valid/ready request channel and a valid/ready response channel. One operation is issued per cycle through a two-stage pipeline: operand register, then per-port result buffer. Full backpressure is honoured on both sides.

## Interface
- No parameters; data width fixed at 32.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req0_valid` input 1: port 0 request valid.
- `req0_ready` output 1: port 0 request accepted this cycle when high together with `req0_valid`.
- `req0_in1`, `req0_in2` input 32: port 0 operands.
- `req0_type` input 1: port 0 operation (0 = ADD, 1 = SUB).
- `req1_valid`, `req1_ready`, `req1_in1`, `req1_in2`, `req1_type`: same as port 0, for port 1.
- `rsp0_valid` output 1: port 0 result valid.
- `rsp0_ready` input 1: port 0 consumer ready.
- `rsp0_out` output 32: port 0 result.
- `rsp1_valid`, `rsp1_ready`, `rsp1_out`: same as port 0, for port 1.

## Operation
- **Stage A:** one operand register holding `in1`, `in2`, `type`, a `tag` (the port number) and `a_valid`.
- **Stage B:** one result buffer per port, each holding a 32-bit result and a `b_valid`. `rspX_valid = b_validX` and `rspX_out = bufferX`.
- **Shared adder:** a single `alu_adder_rv32i` instance is fed from stage A. Arithmetic is modulo 2^32. No flags are produced and overflow wraps silently, e.g. 0xFFFFFFFF + 1 = 0 and 0 - 1 = 0xFFFFFFFF.
- **Stage A advance:** `a_move = a_valid & (~b_valid[tag] | rsp_ready[tag])`. On `a_move`, the adder output is written into buffer[tag] and `b_valid[tag]` is set.
- **Buffer drain:** a buffer clears when its port handshakes (`rspX_valid & rspX_ready`) and no new write to that buffer occurs in the same cycle. A simultaneous drain and write keeps `b_valid` at 1 with the new data.
- **Stage A free:** `a_free = ~a_valid | a_move`.
- **Grant:**
  - Only one port valid → grant that port.
  - Both ports valid → grant the port that is not `last_grant`.
  - `reqX_ready = a_free & (grant == X)`.
  - The non-granted port sees ready = 0.
- **Accept:** on a `reqX_valid & reqX_ready` handshake, stage A loads port X's operands, sets `tag = X` and sets `a_valid`. `last_grant` is updated to X only on an accepted handshake.
- **Stage A clear:** if `a_move` occurs and there is no accept, `a_valid` clears.
- **Arbiter state:** `last_grant` is a 1-bit register, reset to 1, so port 0 wins the first tie.
- **Ordering:** results for a given port return in issue order. Each port has at most 2 operations in flight (one in stage A, one in its buffer).
- **Stall isolation:** a stalled port (buffer full, `rsp_ready` low) blocks stage A only while stage A holds that port's tag. The other port resumes once stage A drains.
- **Reset:** asserting `rst_n` low at any time, including mid-operation, discards all in-flight operations immediately (asynchronous). Reset values:
  - `a_valid` = 0
  - `b_valid0` = 0, `b_valid1` = 0
  - `last_grant` = 1
  - `rsp0_out` = 0, `rsp1_out` = 0
  - `req0_ready` = `req1_ready` = 0 while reset is asserted
  - `rsp0_valid` = `rsp1_valid` = 0

## Timing
- **Latency:** 2 cycles. A request accepted at edge k is in stage A after edge k and appears as `rspX_valid` after edge k+1, provided buffer X is free or draining at edge k+1.
- **Throughput:** 1 operation per cycle sustained across both ports. Ports alternate under continuous contention.
- **Combinational paths:**
  - `reqX_ready` depends on both `req*_valid`, `last_grant`, `a_valid`, `tag`, `b_valid` and `rsp*_ready`.
  - There is no path from `reqX_valid` to `reqX_ready`.
  - `rsp*_valid` and `rsp*_out` are registered outputs.
- **Request holding:** requesters must hold `valid` and operands stable until accepted. The arbiter never drops a valid request, and each port is granted within 2 cycles of stage A becoming free.

## Test plan
- **Single op:** reset, then `req0` ADD 5 + 7 with `rsp0_ready` = 1 → `rsp0_valid` high 2 cycles after accept, `rsp0_out` = 12; `rsp1_valid` stays 0.
- **Contention:** both ports valid every cycle with `rsp*_ready` = 1; port 0 SUB 10 - 3, port 1 ADD 0xFFFFFFFF + 1.
  - Accepts alternate 0, 1, 0, 1, starting with port 0.
  - Port 0 results are 7; port 1 results are 0x00000000.
  - One result per cycle.
- **Backpressure:**
  - Hold `rsp0_ready` = 0 and issue 3 port-0 requests → 2 accepted, `req0_ready` = 0 afterwards.
  - A port-1 request stays blocked while stage A holds tag 0.
  - Raise `rsp0_ready` → results drain in order, then port 1 proceeds.
- **Simultaneous drain and write:** `rsp0_ready` = 1 while a new port-0 result arrives → `rsp0_valid` stays 1 with no bubble and no lost or duplicated result.
- **Reset mid-operation:** assert `rst_n` = 0 with stage A and both buffers full → all valids 0 immediately, `rsp*_out` = 0. After release, the next tie grants port 0.
- **Random soak:** random valid/ready and operands for 10k cycles → scoreboard matches (in1 ± in2) mod 2^32 per port, in order, with no starvation.
